// File: rtl/fractional_multiplier.sv
// fractional_multiplier: serial shift-add multiplier for 1.xxx mantissas with a
// normalized, truncated product and an exponent-increment flag.
module fractional_multiplier #(
    parameter int N = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic [N-1:0] product,
    output logic         exp_inc,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N + 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] FINISH  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  mq_reg;
    logic [N:0]    acc;
    logic [N:0]    sum;
    logic [CW-1:0] cnt;

    assign sum  = acc + (mq_reg[0] ? {1'b0, a_reg} : '0);
    assign busy = state != IDLE;
    assign done = state == FINISH;

    // On the last iteration {sum, mq_reg[N-1:1]} is the full 2N-bit product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            mq_reg  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            exp_inc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= multiplicand;
                        mq_reg <= multiplier;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc    <= {1'b0, sum[N:1]};
                    mq_reg <= {sum[0], mq_reg[N-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= FINISH;
                        product <= sum[N] ? sum[N:1] : sum[N-1:0];
                        exp_inc <= sum[N];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
